exp04_key_pulser: RTL and testbench



---
 rtl/exp04_key_pulser_if.sv | 12 +
 rtl/exp04_key_pulser.sv | 159 +++++++++++++++
 tb/tb_exp04_key_pulser.sv | 134 +++++++++++++
 3 files changed

// File: rtl/exp04_key_pulser_if.sv
// Key front-end bundle: raw active-low buttons in, debounced level and event strobes out.
interface exp04_key_pulser_if #(
  parameter int NUM_KEYS = 3
);
  logic [NUM_KEYS-1:0] keys_n;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] pulse;
  logic [NUM_KEYS-1:0] released;

  modport master (output keys_n, input pressed, pulse, released);
  modport slave  (input keys_n, output pressed, pulse, released);
endinterface

// File: rtl/exp04_key_pulser.sv
// Per-key two-flop synchronizer, counter debouncer and press/release strobes for KEY[3:1].
// Optional auto-repeat (HOLD -> REPEAT pulses) is compiled only when KEY_AUTOREPEAT_EN is defined.
module exp04_key_pulser #(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic                 clk,
  input  logic                 rst,
  exp04_key_pulser_if.slave    kp
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCNT_W  = $clog2(RPT_MAX + 1);
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);
`endif

  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_check
    $error("exp04_key_pulser: need DEBOUNCE_CYCLES >= 1, REPEAT_DELAY >= 2, REPEAT_PERIOD >= 2");
  end

  logic [NUM_KEYS-1:0] pressed_vec;
  logic [NUM_KEYS-1:0] pulse_vec;
  logic [NUM_KEYS-1:0] released_vec;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic             sync1_q;
    logic             sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pressed_q;
    logic             pressed_d;
    logic             rise;
    logic             fall;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             pulse_q;
    logic             pulse_d;
    logic             released_q;
    logic             released_d;
`ifdef KEY_AUTOREPEAT_EN
    logic [RCNT_W-1:0] rcnt_q;
    logic [RCNT_W-1:0] rcnt_d;
`endif

    // sync_q is active-low, so equality with pressed_q means the key disagrees with the debounced level
    always_comb begin
      pressed_d = pressed_q;
      cnt_d     = '0;
      if (sync_q == pressed_q) begin
        if (cnt_q == CNT_LAST) begin
          pressed_d = ~pressed_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    assign rise = pressed_d & ~pressed_q;
    assign fall = ~pressed_d & pressed_q;

    // Release is checked before any due repeat so it always wins the tie
    always_comb begin
      state_d    = state_q;
      pulse_d    = 1'b0;
      released_d = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rcnt_d     = rcnt_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (rise) begin
            pulse_d = 1'b1;
            state_d = ST_HOLD;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d  = '0;
`endif
          end
        end
        ST_HOLD: begin
          if (fall) begin
            released_d = 1'b1;
            state_d    = ST_IDLE;
`ifdef KEY_AUTOREPEAT_EN
            rcnt_d     = '0;
          end else if (rcnt_q == DELAY_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
            state_d = ST_REPEAT;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
`endif
          end
        end
`ifdef KEY_AUTOREPEAT_EN
        ST_REPEAT: begin
          if (fall) begin
            released_d = 1'b1;
            state_d    = ST_IDLE;
            rcnt_d     = '0;
          end else if (rcnt_q == PERIOD_LAST) begin
            pulse_d = 1'b1;
            rcnt_d  = '0;
          end else begin
            rcnt_d = rcnt_q + RCNT_W'(1);
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync1_q    <= 1'b1;
        sync_q     <= 1'b1;
        cnt_q      <= '0;
        pressed_q  <= 1'b0;
        state_q    <= ST_IDLE;
        pulse_q    <= 1'b0;
        released_q <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q     <= '0;
`endif
      end else begin
        sync1_q    <= kp.keys_n[k];
        sync_q     <= sync1_q;
        cnt_q      <= cnt_d;
        pressed_q  <= pressed_d;
        state_q    <= state_d;
        pulse_q    <= pulse_d;
        released_q <= released_d;
`ifdef KEY_AUTOREPEAT_EN
        rcnt_q     <= rcnt_d;
`endif
      end
    end

    assign pressed_vec[k]  = pressed_q;
    assign pulse_vec[k]    = pulse_q;
    assign released_vec[k] = released_q;
  end

  assign kp.pressed  = pressed_vec;
  assign kp.pulse    = pulse_vec;
  assign kp.released = released_vec;

endmodule

// File: tb/tb_exp04_key_pulser.sv
// Directed bench for exp04_key_pulser with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3.
module tb_exp04_key_pulser;
  localparam int NK = 3;
`ifdef KEY_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  exp04_key_pulser_if #(.NUM_KEYS(NK)) kp ();

  exp04_key_pulser #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .kp (kp)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required normal completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input int e, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @edge %0d: observed %b expected %b", tag, e, obs, exp);
    end
  endtask

  // Advance one active edge, then sample outputs 1 time unit later.
  task automatic step(input string tag, input int e,
                      input logic [NK-1:0] ep, input logic [NK-1:0] epu, input logic [NK-1:0] er);
    @(posedge clk);
    #1;
    check({tag, ".pressed"},  e, kp.pressed,  ep);
    check({tag, ".pulse"},    e, kp.pulse,    epu);
    check({tag, ".released"}, e, kp.released, er);
  endtask

  initial begin
    kp.keys_n = '1;
    rst       = 1'b1;

    // Reset state
    for (int e = 0; e < 3; e++) step("reset", e, 3'b000, 3'b000, 3'b000);
    rst = 1'b0;
    for (int e = 0; e < 3; e++) step("idle", e, 3'b000, 3'b000, 3'b000);

    // Clean press on key 0: low for edges 0..7, first high sample at edge 8
    for (int e = 0; e < 16; e++) begin
      if (e == 0) kp.keys_n = 3'b110;
      if (e == 8) kp.keys_n = 3'b111;
      step("clean", e,
           (e >= 5 && e < 13) ? 3'b001 : 3'b000,
           (e == 5)  ? 3'b001 : 3'b000,
           (e == 13) ? 3'b001 : 3'b000);
    end

    // Bounce on key 1: never 4 consecutive low samples
    for (int e = 0; e < 28; e++) begin
      kp.keys_n = (e < 20 && ((e / 2) % 2 == 0)) ? 3'b101 : 3'b111;
      step("bounce", e, 3'b000, 3'b000, 3'b000);
    end

    // Auto-repeat on key 2: held for edges 0..39, fall at 45 coincides with a due repeat
    for (int e = 0; e < 52; e++) begin
      if (e == 0)  kp.keys_n = 3'b011;
      if (e == 40) kp.keys_n = 3'b111;
      step("repeat", e,
           (e >= 5 && e < 45) ? 3'b100 : 3'b000,
           (e == 5 || (AR && e >= 15 && e < 45 && (e - 15) % 3 == 0)) ? 3'b100 : 3'b000,
           (e == 45) ? 3'b100 : 3'b000);
    end

    // Simultaneous keys 0 and 2
    for (int e = 0; e < 17; e++) begin
      if (e == 0) kp.keys_n = 3'b010;
      if (e == 8) kp.keys_n = 3'b111;
      step("simul", e,
           (e >= 5 && e < 13) ? 3'b101 : 3'b000,
           (e == 5)  ? 3'b101 : 3'b000,
           (e == 13) ? 3'b101 : 3'b000);
    end

    // Release vs repeat: pressed[2] falls at E+13 = 18, exactly when a repeat is due
    for (int e = 0; e < 30; e++) begin
      if (e == 0)  kp.keys_n = 3'b011;
      if (e == 13) kp.keys_n = 3'b111;
      step("relwin", e,
           (e >= 5 && e < 18) ? 3'b100 : 3'b000,
           (e == 5 || (AR && e == 15)) ? 3'b100 : 3'b000,
           (e == 18) ? 3'b100 : 3'b000);
    end

    // Key 2 must be back in IDLE: a new press gives a fresh pulse at 5 and first repeat at 15
    for (int e = 0; e < 20; e++) begin
      if (e == 0)  kp.keys_n = 3'b011;
      if (e == 12) kp.keys_n = 3'b111;
      step("repress", e,
           (e >= 5 && e < 17) ? 3'b100 : 3'b000,
           (e == 5 || (AR && e == 15)) ? 3'b100 : 3'b000,
           (e == 17) ? 3'b100 : 3'b000);
    end

    // Reset while key 0 held: reset at edge 7, new press at edge 13, no release for the old press
    for (int e = 0; e < 28; e++) begin
      if (e == 0)  kp.keys_n = 3'b110;
      if (e == 7)  rst = 1'b1;
      if (e == 8)  rst = 1'b0;
      if (e == 16) kp.keys_n = 3'b111;
      step("rstheld", e,
           ((e >= 5 && e < 7) || (e >= 13 && e < 21)) ? 3'b001 : 3'b000,
           (e == 5 || e == 13) ? 3'b001 : 3'b000,
           (e == 21) ? 3'b001 : 3'b000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
